mem_bus_master: RTL and testbench
=================================

MEM_BUS_MASTER -- requirements
Module: mem_bus_master

Interface
REQ-001 The block SHALL take parameters: DATA_WIDTH, 32, bus data width; ADDR_WIDTH, 16, word address width.
REQ-002 The block SHALL have exactly one clock and a synchronous, active-high reset, as ports clk and rst.
REQ-003 The block SHALL have port: clk  in  1  rising-edge clock shared with the memory target.
REQ-004 The block SHALL have port: rst  in  1  synchronous active-high reset.
REQ-005 The block SHALL have port: data  inout  DATA_WIDTH  shared tri-state memory data bus.
REQ-006 The block SHALL have port: address  out  ADDR_WIDTH  memory word address.
REQ-007 The block SHALL have port: wr  out  1  write strobe; the target writes at a posedge while it is high and drives data while it is low.
REQ-008 The block SHALL have port: cmd_valid  in  1  command offered.
REQ-009 The block SHALL have port: cmd_ready  out  1  command accepted when high together with cmd_valid.
REQ-010 The block SHALL have port: cmd_op  in  2  00 read, 01 write, 10 block copy, 11 reserved.
REQ-011 The block SHALL have port: cmd_addr  in  ADDR_WIDTH  read/write address, or copy source.
REQ-012 The block SHALL have port: cmd_addr2  in  ADDR_WIDTH  copy destination.
REQ-013 The block SHALL have port: cmd_wdata  in  DATA_WIDTH  write data.
REQ-014 The block SHALL have port: cmd_len  in  ADDR_WIDTH  copy length in words.
REQ-015 The block SHALL have port: rsp_valid  out  1  one-cycle completion pulse.
REQ-016 The block SHALL have port: rsp_data  out  DATA_WIDTH  read data, write data echo, or copy word count.
REQ-017 The block SHALL have port: busy  out  1  high whenever the state is not IDLE.

Function
REQ-018 The FSM SHALL have states IDLE, RD, WR, CP_RD, CP_WR and RSP; cmd_ready SHALL be high only in IDLE with rst low.
REQ-019 On accept (cmd_valid & cmd_ready at a posedge), the block SHALL register all cmd_* fields and go to RD (00), WR (01), CP_RD (10 with len≠0), or RSP (10 with len=0, or 11).
REQ-020 RD SHALL last one cycle with address=addr and wr=0; data SHALL be captured into rsp_data at the closing edge; next state RSP.
REQ-021 WR SHALL last one cycle with address=addr, wr=1, data=wdata; rsp_data SHALL be set to wdata; next state RSP.
REQ-022 A copy SHALL alternate CP_RD (address=src+i, wr=0, capture data into an internal buffer) and CP_WR (address=dst+i, wr=1, data=buffer) for i=0..len-1, taking 2*len cycles; after the last CP_WR the next state SHALL be RSP.
REQ-023 Address arithmetic SHALL wrap modulo 2^ADDR_WIDTH; the index counter SHALL be ADDR_WIDTH bits wide.
REQ-024 Copies SHALL proceed in ascending order one word at a time, so overlapping ranges give the defined forward-copy result.
REQ-025 RSP SHALL last exactly one cycle with rsp_valid=1, then return to IDLE; there SHALL be no backpressure.
REQ-026 In RSP, rsp_data SHALL hold: read data; write data; len zero-extended for a copy; 0 for op 11.
REQ-027 rsp_data SHALL hold its value until the next RSP.
REQ-028 Latency from the accept edge SHALL be: rsp_valid in cycle 2 for read/write; cycle 2*len+1 for a copy; cycle 1 for len=0 or op 11.
REQ-029 The block SHALL drive data only while wr=1 and SHALL present high-Z otherwise.
REQ-030 wr SHALL be 0 in all states except WR and CP_WR, and SHALL be registered so it is glitch-free.
REQ-031 address SHALL be 0 in IDLE and RSP.
REQ-032 Memory-mapped I/O addresses (0xFFE0-0xFFFC) SHALL receive no special treatment.

Reset
REQ-033 While rst is high at a posedge, the block SHALL go to IDLE and set wr=0, address=0, rsp_valid=0, rsp_data=0, busy=0, and clear the buffer and index; cmd_ready SHALL be 0 while rst is high.
REQ-034 A reset mid-operation SHALL abandon the command with no rsp_valid; words already written SHALL remain written.

Structure
REQ-035 The op codes (OP_READ, OP_WRITE, OP_COPY, OP_RSVD) and the state encoding SHALL reside in the shared package mem_bus_pkg.
REQ-036 The block SHALL be a single module with no sub-module; the tri-state driver SHALL be a continuous assign.

Verification
REQ-037 The bench SHALL use the existing memory target on the same clk. Write 0x0010←0xDEADBEEF, then read 0x0010 -> rsp_data=0xDEADBEEF, with rsp_valid in cycle 2 after accept.
REQ-038 Copy src 0x0100, dst 0x0200, len 4 -> mem[0x0200..0x0203] equals the source, exactly 4 wr pulses, rsp_valid in cycle 9, rsp_data=4.
REQ-039 Copy with len=0 -> rsp_valid in cycle 1, rsp_data=0, no wr pulse, and data stays high-Z throughout.
REQ-040 Copy src 0x0300, dst 0xFFFF, len 2 -> mem[0xFFFF]=old mem[0x0300] and mem[0x0000]=old mem[0x0301].
REQ-041 Assert rst during the third cycle of a len-4 copy -> wr=0 and busy=0 after that edge, no rsp_valid, and cmd_ready=1 once rst is released.
REQ-042 With sw=0x5, read 0xFFE0 -> rsp_data=0x00000005.

Source files
------------

// File: rtl/mem_bus_pkg.sv
// Purpose: op codes and FSM state encoding shared by the memory bus master and its users.
// Latency: none (types and constants only).
// Backpressure: none (types and constants only).
package mem_bus_pkg;

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_COPY  = 2'b10;
    localparam logic [1:0] OP_RSVD  = 2'b11;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD    = 3'd1,
        WR    = 3'd2,
        CP_RD = 3'd3,
        CP_WR = 3'd4,
        RSP   = 3'd5
    } state_t;

endpackage

// File: rtl/mem_bus_master.sv
// Purpose: single-port memory bus master doing read, write and forward block copy over a tri-state data bus.
// Latency: rsp_valid 2 cycles after accept for read/write, 2*len+1 for copy, 1 for empty copy or reserved op.
// Backpressure: one command at a time (cmd_ready only in IDLE); the response pulse cannot be stalled.
module mem_bus_master
    import mem_bus_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    inout  wire  [DATA_WIDTH-1:0] data,
    output logic [ADDR_WIDTH-1:0] address,
    output logic                  wr,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_op,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [ADDR_WIDTH-1:0] cmd_addr2,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    input  logic [ADDR_WIDTH-1:0] cmd_len,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  busy
);

    state_t                state;
    logic [ADDR_WIDTH-1:0] src_q;
    logic [ADDR_WIDTH-1:0] dst_q;
    logic [ADDR_WIDTH-1:0] len_q;
    logic [ADDR_WIDTH-1:0] idx;
    logic [ADDR_WIDTH-1:0] idx_inc;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] buf_q;
    logic [DATA_WIDTH-1:0] drive_dat;

    // Handshake and status derive straight from the state register; reset blocks acceptance at once.
    assign cmd_ready = (state == IDLE) && !rst;
    assign busy      = (state != IDLE);

    // Index arithmetic stays ADDR_WIDTH wide so source/destination addresses wrap naturally.
    assign idx_inc = idx + ADDR_WIDTH'(1);

    // Bus is driven only while the registered write strobe is high; copy writes the buffered word.
    assign drive_dat = (state == CP_WR) ? buf_q : wdata_q;
    assign data      = wr ? drive_dat : {DATA_WIDTH{1'bz}};

    // Command FSM with registered bus outputs (address, wr) and response registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            address   <= '0;
            wr        <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            src_q     <= '0;
            dst_q     <= '0;
            len_q     <= '0;
            wdata_q   <= '0;
            buf_q     <= '0;
            idx       <= '0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    address <= '0;
                    wr      <= 1'b0;
                    if (cmd_valid && cmd_ready) begin
                        src_q   <= cmd_addr;
                        dst_q   <= cmd_addr2;
                        len_q   <= cmd_len;
                        wdata_q <= cmd_wdata;
                        idx     <= '0;
                        case (cmd_op)
                            OP_READ: begin
                                state   <= RD;
                                address <= cmd_addr;
                            end
                            OP_WRITE: begin
                                state   <= WR;
                                address <= cmd_addr;
                                wr      <= 1'b1;
                            end
                            OP_COPY: begin
                                if (cmd_len != '0) begin
                                    state   <= CP_RD;
                                    address <= cmd_addr;
                                end else begin
                                    // Empty copy completes immediately and reports a zero count.
                                    state     <= RSP;
                                    rsp_valid <= 1'b1;
                                    rsp_data  <= '0;
                                end
                            end
                            default: begin
                                state     <= RSP;
                                rsp_valid <= 1'b1;
                                rsp_data  <= '0;
                            end
                        endcase
                    end
                end
                RD: begin
                    rsp_data  <= data;
                    rsp_valid <= 1'b1;
                    address   <= '0;
                    state     <= RSP;
                end
                WR: begin
                    rsp_data  <= wdata_q;
                    rsp_valid <= 1'b1;
                    address   <= '0;
                    wr        <= 1'b0;
                    state     <= RSP;
                end
                CP_RD: begin
                    buf_q   <= data;
                    address <= dst_q + idx;
                    wr      <= 1'b1;
                    state   <= CP_WR;
                end
                CP_WR: begin
                    wr <= 1'b0;
                    if (idx_inc == len_q) begin
                        rsp_data  <= DATA_WIDTH'(len_q);
                        rsp_valid <= 1'b1;
                        address   <= '0;
                        state     <= RSP;
                    end else begin
                        // Word i is written before word i+1 is read, giving forward-copy overlap semantics.
                        idx     <= idx_inc;
                        address <= src_q + idx_inc;
                        state   <= CP_RD;
                    end
                end
                RSP: begin
                    address <= '0;
                    wr      <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    address <= '0;
                    wr      <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_master.sv
// Purpose: self-checking bench for mem_bus_master against a word memory target with one switch register.
// Latency: responses checked against expected cycle counts from the accept edge.
// Backpressure: none exercised; the master accepts one command at a time.
module tb_mem_bus_master;

    localparam int DW = 32;
    localparam int AW = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    wire  [DW-1:0] data;
    logic [AW-1:0] address;
    logic          wr;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic [AW-1:0] cmd_addr;
    logic [AW-1:0] cmd_addr2;
    logic [DW-1:0] cmd_wdata;
    logic [AW-1:0] cmd_len;
    logic          rsp_valid;
    logic [DW-1:0] rsp_data;
    logic          busy;
    logic [DW-1:0] sw;

    logic [DW-1:0] mem     [0:65535];
    bit            mem_vld [0:65535];
    logic [DW-1:0] tgt_rd;
    int            cyc       = 0;
    int            wr_pulses = 0;
    int            n_checks  = 0;
    int            n_fail    = 0;
    logic [DW-1:0] exp_q [$];
    int            lat_q [$];

    mem_bus_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .data      (data),
        .address   (address),
        .wr        (wr),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_addr  (cmd_addr),
        .cmd_addr2 (cmd_addr2),
        .cmd_wdata (cmd_wdata),
        .cmd_len   (cmd_len),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .busy      (busy)
    );

    // Unwritten words hold a fixed address-derived pattern.
    function automatic logic [DW-1:0] mem_val(input logic [AW-1:0] a);
        return mem_vld[a] ? mem[a] : {~a, a};
    endfunction

    // Memory target: switch register at 0xFFE0, drives the bus whenever wr is low.
    always_comb begin
        tgt_rd = mem_val(address);
        if (address == 16'hFFE0) tgt_rd = sw;
    end
    assign data = wr ? {DW{1'bz}} : tgt_rd;

    // Target write port and cycle / write-pulse counters.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (wr) begin
            mem[address]     <= data;
            mem_vld[address] <= 1'b1;
            wr_pulses        <= wr_pulses + 1;
        end
    end

    // Offer one command for a single cycle; records expected response and the accept cycle.
    task automatic send_cmd(input logic [1:0] op, input logic [AW-1:0] a, input logic [AW-1:0] a2,
                            input logic [AW-1:0] len, input logic [DW-1:0] wd, input bit push,
                            input logic [DW-1:0] exp_d, input int exp_l, output int acc);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_addr  = a;
        cmd_addr2 = a2;
        cmd_len   = len;
        cmd_wdata = wd;
        acc       = cyc;
        if (push) begin
            exp_q.push_back(exp_d);
            lat_q.push_back(exp_l);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    // Wait (bounded) for rsp_valid, starting at the current negedge.
    task automatic wait_rsp(input int acc, input int budget, output bit got, output int lat,
                            output logic [DW-1:0] d);
        got = 1'b0;
        lat = 0;
        d   = '0;
        for (int i = 0; i < budget; i++) begin
            if (rsp_valid === 1'b1) begin
                got = 1'b1;
                lat = cyc - acc;
                d   = rsp_data;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (wr !== 1'b0) begin n_fail++; $display("FAIL reset_wr: got %b want 0", wr); end
        n_checks++; if (address !== 16'h0) begin n_fail++; $display("FAIL reset_address: got %h want 0000", address); end
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
        n_checks++; if (rsp_data !== 32'h0) begin n_fail++; $display("FAIL reset_rsp_data: got %h want 0", rsp_data); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL reset_cmd_ready: got %b want 0", cmd_ready); end
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_cmd_ready: got %b want 1", cmd_ready); end
    endtask

    task automatic test_write_read();
        int acc, lat, el, w0;
        bit got;
        logic [DW-1:0] d, ed;
        w0 = wr_pulses;
        send_cmd(2'b01, 16'h0010, 16'h0, 16'h0, 32'hDEADBEEF, 1'b1, 32'hDEADBEEF, 2, acc);
        wait_rsp(acc, 20, got, lat, d);
        ed = exp_q.pop_front(); el = lat_q.pop_front();
        n_checks++;
        if (!got) begin n_fail++; $display("FAIL write_rsp: no rsp_valid within budget"); end
        else begin
            n_checks++; if (d !== ed) begin n_fail++; $display("FAIL write_rsp_data: got %h want %h", d, ed); end
            n_checks++; if (lat != el) begin n_fail++; $display("FAIL write_latency: got %0d want %0d", lat, el); end
        end
        n_checks++; if (mem_val(16'h0010) !== 32'hDEADBEEF) begin n_fail++; $display("FAIL write_mem: got %h want deadbeef", mem_val(16'h0010)); end
        n_checks++; if (wr_pulses - w0 != 1) begin n_fail++; $display("FAIL write_pulses: got %0d want 1", wr_pulses - w0); end

        send_cmd(2'b00, 16'h0010, 16'h0, 16'h0, 32'h0, 1'b1, 32'hDEADBEEF, 2, acc);
        wait_rsp(acc, 20, got, lat, d);
        ed = exp_q.pop_front(); el = lat_q.pop_front();
        n_checks++;
        if (!got) begin n_fail++; $display("FAIL read_rsp: no rsp_valid within budget"); end
        else begin
            n_checks++; if (d !== ed) begin n_fail++; $display("FAIL read_rsp_data: got %h want %h", d, ed); end
            n_checks++; if (lat != el) begin n_fail++; $display("FAIL read_latency: got %0d want %0d", lat, el); end
        end
        @(negedge clk);
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rsp_pulse_width: got %b want 0", rsp_valid); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL read_idle_busy: got %b want 0", busy); end
        repeat (3) @(negedge clk);
        n_checks++; if (rsp_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rsp_data_hold: got %h want deadbeef", rsp_data); end
    endtask

    task automatic test_copy();
        int acc, lat, el, w0;
        bit got;
        logic [DW-1:0] d, ed;
        logic [DW-1:0] src [4];
        for (int i = 0; i < 4; i++) src[i] = mem_val(16'h0100 + 16'(i));
        w0 = wr_pulses;
        send_cmd(2'b10, 16'h0100, 16'h0200, 16'd4, 32'h0, 1'b1, 32'd4, 9, acc);
        wait_rsp(acc, 40, got, lat, d);
        ed = exp_q.pop_front(); el = lat_q.pop_front();
        n_checks++;
        if (!got) begin n_fail++; $display("FAIL copy_rsp: no rsp_valid within budget"); end
        else begin
            n_checks++; if (d !== ed) begin n_fail++; $display("FAIL copy_rsp_data: got %h want %h", d, ed); end
            n_checks++; if (lat != el) begin n_fail++; $display("FAIL copy_latency: got %0d want %0d", lat, el); end
        end
        n_checks++; if (wr_pulses - w0 != 4) begin n_fail++; $display("FAIL copy_pulses: got %0d want 4", wr_pulses - w0); end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (mem_val(16'h0200 + 16'(i)) !== src[i]) begin
                n_fail++; $display("FAIL copy_mem[%0d]: got %h want %h", i, mem_val(16'h0200 + 16'(i)), src[i]);
            end
        end
    endtask

    task automatic test_copy_len0();
        int acc, lat, el, w0;
        bit got;
        logic [DW-1:0] d, ed, old_dst;
        old_dst = mem_val(16'h0700);
        w0 = wr_pulses;
        send_cmd(2'b10, 16'h0100, 16'h0700, 16'd0, 32'h0, 1'b1, 32'd0, 1, acc);
        wait_rsp(acc, 20, got, lat, d);
        ed = exp_q.pop_front(); el = lat_q.pop_front();
        n_checks++;
        if (!got) begin n_fail++; $display("FAIL len0_rsp: no rsp_valid within budget"); end
        else begin
            n_checks++; if (d !== ed) begin n_fail++; $display("FAIL len0_rsp_data: got %h want %h", d, ed); end
            n_checks++; if (lat != el) begin n_fail++; $display("FAIL len0_latency: got %0d want %0d", lat, el); end
        end
        repeat (2) @(negedge clk);
        n_checks++; if (wr_pulses - w0 != 0) begin n_fail++; $display("FAIL len0_pulses: got %0d want 0", wr_pulses - w0); end
        n_checks++; if (mem_val(16'h0700) !== old_dst) begin n_fail++; $display("FAIL len0_mem: got %h want %h", mem_val(16'h0700), old_dst); end
    endtask

    task automatic test_copy_wrap();
        int acc, lat, el;
        bit got;
        logic [DW-1:0] d, ed, s0, s1;
        s0 = mem_val(16'h0300);
        s1 = mem_val(16'h0301);
        send_cmd(2'b10, 16'h0300, 16'hFFFF, 16'd2, 32'h0, 1'b1, 32'd2, 5, acc);
        wait_rsp(acc, 20, got, lat, d);
        ed = exp_q.pop_front(); el = lat_q.pop_front();
        n_checks++;
        if (!got) begin n_fail++; $display("FAIL wrap_rsp: no rsp_valid within budget"); end
        else begin
            n_checks++; if (d !== ed) begin n_fail++; $display("FAIL wrap_rsp_data: got %h want %h", d, ed); end
            n_checks++; if (lat != el) begin n_fail++; $display("FAIL wrap_latency: got %0d want %0d", lat, el); end
        end
        n_checks++; if (mem_val(16'hFFFF) !== s0) begin n_fail++; $display("FAIL wrap_mem_ffff: got %h want %h", mem_val(16'hFFFF), s0); end
        n_checks++; if (mem_val(16'h0000) !== s1) begin n_fail++; $display("FAIL wrap_mem_0000: got %h want %h", mem_val(16'h0000), s1); end
    endtask

    task automatic test_copy_overlap();
        int acc, lat, el;
        bit got;
        logic [DW-1:0] d, ed;
        logic [DW-1:0] m [4];
        for (int i = 0; i < 4; i++) m[i] = mem_val(16'h0400 + 16'(i));
        for (int i = 0; i < 3; i++) m[i + 1] = m[i];
        send_cmd(2'b10, 16'h0400, 16'h0401, 16'd3, 32'h0, 1'b1, 32'd3, 7, acc);
        wait_rsp(acc, 30, got, lat, d);
        ed = exp_q.pop_front(); el = lat_q.pop_front();
        n_checks++;
        if (!got) begin n_fail++; $display("FAIL overlap_rsp: no rsp_valid within budget"); end
        else begin
            n_checks++; if (d !== ed) begin n_fail++; $display("FAIL overlap_rsp_data: got %h want %h", d, ed); end
            n_checks++; if (lat != el) begin n_fail++; $display("FAIL overlap_latency: got %0d want %0d", lat, el); end
        end
        for (int i = 1; i < 4; i++) begin
            n_checks++;
            if (mem_val(16'h0400 + 16'(i)) !== m[i]) begin
                n_fail++; $display("FAIL overlap_mem[%0d]: got %h want %h", i, mem_val(16'h0400 + 16'(i)), m[i]);
            end
        end
    endtask

    task automatic test_reserved();
        int acc, lat, el, w0;
        bit got;
        logic [DW-1:0] d, ed;
        w0 = wr_pulses;
        send_cmd(2'b11, 16'h0123, 16'h0456, 16'd5, 32'hCAFEF00D, 1'b1, 32'd0, 1, acc);
        wait_rsp(acc, 20, got, lat, d);
        ed = exp_q.pop_front(); el = lat_q.pop_front();
        n_checks++;
        if (!got) begin n_fail++; $display("FAIL rsvd_rsp: no rsp_valid within budget"); end
        else begin
            n_checks++; if (d !== ed) begin n_fail++; $display("FAIL rsvd_rsp_data: got %h want %h", d, ed); end
            n_checks++; if (lat != el) begin n_fail++; $display("FAIL rsvd_latency: got %0d want %0d", lat, el); end
        end
        n_checks++; if (wr_pulses - w0 != 0) begin n_fail++; $display("FAIL rsvd_pulses: got %0d want 0", wr_pulses - w0); end
    endtask

    task automatic test_mmio();
        int acc, lat, el;
        bit got;
        logic [DW-1:0] d, ed;
        sw = 32'h5;
        send_cmd(2'b00, 16'hFFE0, 16'h0, 16'h0, 32'h0, 1'b1, 32'h00000005, 2, acc);
        wait_rsp(acc, 20, got, lat, d);
        ed = exp_q.pop_front(); el = lat_q.pop_front();
        n_checks++;
        if (!got) begin n_fail++; $display("FAIL mmio_rsp: no rsp_valid within budget"); end
        else begin
            n_checks++; if (d !== ed) begin n_fail++; $display("FAIL mmio_rsp_data: got %h want %h", d, ed); end
            n_checks++; if (lat != el) begin n_fail++; $display("FAIL mmio_latency: got %0d want %0d", lat, el); end
        end
        send_cmd(2'b01, 16'hFFE4, 16'h0, 16'h0, 32'h12345678, 1'b1, 32'h12345678, 2, acc);
        wait_rsp(acc, 20, got, lat, d);
        ed = exp_q.pop_front(); el = lat_q.pop_front();
        n_checks++;
        if (!got) begin n_fail++; $display("FAIL mmio_wr_rsp: no rsp_valid within budget"); end
        else begin
            n_checks++; if (d !== ed) begin n_fail++; $display("FAIL mmio_wr_rsp_data: got %h want %h", d, ed); end
        end
        n_checks++; if (mem_val(16'hFFE4) !== 32'h12345678) begin n_fail++; $display("FAIL mmio_wr_mem: got %h want 12345678", mem_val(16'hFFE4)); end
    endtask

    task automatic test_reset_mid_copy();
        int acc;
        bit seen;
        logic [DW-1:0] s0, old1;
        s0   = mem_val(16'h0500);
        old1 = mem_val(16'h0601);
        send_cmd(2'b10, 16'h0500, 16'h0600, 16'd4, 32'h0, 1'b0, 32'h0, 0, acc);
        @(negedge clk);
        @(negedge clk);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL midrst_busy_before: got %b want 1", busy); end
        rst = 1'b1;
        @(negedge clk);
        n_checks++; if (wr !== 1'b0) begin n_fail++; $display("FAIL midrst_wr: got %b want 0", wr); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b want 0", busy); end
        n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_rsp_valid: got %b want 0", rsp_valid); end
        n_checks++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL midrst_cmd_ready_in_rst: got %b want 0", cmd_ready); end
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_cmd_ready_after: got %b want 1", cmd_ready); end
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (rsp_valid === 1'b1) seen = 1'b1;
            @(negedge clk);
        end
        n_checks++; if (seen) begin n_fail++; $display("FAIL midrst_no_rsp: got rsp_valid want none"); end
        n_checks++; if (mem_val(16'h0600) !== s0) begin n_fail++; $display("FAIL midrst_mem0: got %h want %h", mem_val(16'h0600), s0); end
        n_checks++; if (mem_val(16'h0601) !== old1) begin n_fail++; $display("FAIL midrst_mem1: got %h want %h", mem_val(16'h0601), old1); end
    endtask

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_addr  = '0;
        cmd_addr2 = '0;
        cmd_wdata = '0;
        cmd_len   = '0;
        sw        = 32'h0;
        test_reset();
        test_write_read();
        test_copy();
        test_copy_len0();
        test_copy_wrap();
        test_copy_overlap();
        test_reserved();
        test_mmio();
        test_reset_mid_copy();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
